alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 21 ++
 rtl/alu_arbiter_rr_arb2.sv | 41 ++++
 rtl/alu_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the FSM state enum, the 3-bit ALU opcodes and the default data width.
`timescale 1ns/1ps
package alu_arbiter_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-request arbiter: round-robin with a last-grant pointer by default,
// fixed priority to request 0 when ALU_ARBITER_FIXED_PRIO_EN is defined.
`timescale 1ns/1ps
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

`ifdef ALU_ARBITER_FIXED_PRIO_EN

  assign grant = {req[1] & ~req[0], req[0]};

  logic unused_inputs;
  assign unused_inputs = &{1'b0, clk, rst_n, update};

`else

  // last_grant = 1 means requester 1 won most recently, so requester 0 wins the next tie
  logic last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (update && (grant != 2'b00)) begin
      last_grant <= grant[1];
    end
  end

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

`endif

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external ALU, one operation in flight.
// Optional build macro: ALU_ARBITER_FIXED_PRIO_EN (fixed priority to requester 0).
`timescale 1ns/1ps
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero,
  output logic             busy
);

  state_t           state;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             id_reg;
  logic [WIDTH-1:0] res_reg;
  logic             zero_reg;
  logic [1:0]       rsp_valid_reg;
  logic             busy_reg;

  logic [1:0] grant;
  logic       in_idle;
  logic       accept;
  logic       rsp_taken;

  // Ready is gated by rst_n so nothing looks accepted while reset is held.
  assign in_idle = (state == IDLE) && rst_n;
  assign accept  = in_idle && (req0_valid || req1_valid);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1_valid, req0_valid}),
    .update (accept),
    .grant  (grant)
  );

  assign req0_ready = in_idle && grant[0];
  assign req1_ready = in_idle && grant[1];

  assign rsp_taken = |(rsp_valid_reg & {rsp1_ready, rsp0_ready});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      id_reg        <= 1'b0;
      res_reg       <= '0;
      zero_reg      <= 1'b0;
      rsp_valid_reg <= 2'b00;
      busy_reg      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_reg   <= grant[1] ? req1_op : req0_op;
            a_reg    <= grant[1] ? req1_a  : req0_a;
            b_reg    <= grant[1] ? req1_b  : req0_b;
            id_reg   <= grant[1];
            busy_reg <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          res_reg       <= alu_res;
          zero_reg      <= alu_zero;
          rsp_valid_reg <= id_reg ? 2'b10 : 2'b01;
          state         <= RESP;
        end
        RESP: begin
          if (rsp_taken) begin
            rsp_valid_reg <= 2'b00;
            busy_reg      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          rsp_valid_reg <= 2'b00;
          busy_reg      <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  // The ALU sees the operand registers at all times, so its inputs only move on acceptance.
  assign alu_a      = a_reg;
  assign alu_b      = b_reg;
  assign alu_op     = op_reg;
  assign rsp_res    = res_reg;
  assign rsp_zero   = zero_reg;
  assign rsp0_valid = rsp_valid_reg[0];
  assign rsp1_valid = rsp_valid_reg[1];
  assign busy       = busy_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small behavioural ALU.
// Build with ALU_ARBITER_FIXED_PRIO_EN defined to expect fixed-priority grants.
`timescale 1ns/1ps
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp_res;
  logic         rsp_zero;
  logic [W-1:0] alu_a, alu_b, alu_res;
  logic [2:0]   alu_op;
  logic         alu_zero;
  logic         busy;

  int checks = 0;
  int failures = 0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_res(rsp_res), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_zero(alu_zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_AND: alu_res = alu_a & alu_b;
      ALU_OR:  alu_res = alu_a | alu_b;
      ALU_ADD: alu_res = alu_a + alu_b;
      ALU_XOR: alu_res = alu_a ^ alu_b;
      ALU_SUB: alu_res = alu_a - alu_b;
      default: alu_res = '0;
    endcase
  end
  assign alu_zero = (alu_res == '0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    int grants[4];
    int ng;
    logic [31:0] exp_a, exp_b;
    bit captured;

    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_op = '0; req1_op = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 0; rsp1_ready = 0;

    #2;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_rsp_res", rsp_res, 0);
    check("rst_rsp_zero", rsp_zero, 0);
    req0_valid = 1; #1;
    check("rst_req_ready", {req1_ready, req0_ready}, 0);
    req0_valid = 0;

    @(negedge clk); rst_n = 1'b1;

    // Single request 0: 5 + 7 with an adding ALU
    @(negedge clk);
    req0_valid = 1; req0_op = ALU_ADD; req0_a = 5; req0_b = 7; rsp0_ready = 1;
    #1;
    check("t27_req_ready", {req1_ready, req0_ready}, 2'b01);
    @(negedge clk); req0_valid = 0; req0_a = 99; #1;
    check("t27_exec_op", alu_op, ALU_ADD);
    check("t27_exec_a", alu_a, 5);
    check("t27_exec_busy", busy, 1);
    check("t27_exec_rspv", rsp0_valid, 0);
    @(negedge clk); #1;
    check("t27_rsp_valid", {rsp1_valid, rsp0_valid}, 2'b01);
    check("t27_rsp_res", rsp_res, 12);
    check("t27_rsp_zero", rsp_zero, 0);
    $display("txn single req0 res=%0d", rsp_res);
    @(negedge clk); #1;
    check("t27_idle_busy", busy, 0);
    check("t27_idle_rspv", rsp0_valid, 0);

    // Reset while EXEC drops the operation
    @(negedge clk);
    req0_valid = 1; req0_op = ALU_ADD; req0_a = 1; req0_b = 2; #1;
    check("t31_accept", req0_ready, 1);
    @(negedge clk); rst_n = 1'b0; #1;
    check("t31_busy", busy, 0);
    check("t31_alu_a", alu_a, 0);
    check("t31_rsp_res", rsp_res, 0);
    check("t31_req_ready", req0_ready, 0);
    @(negedge clk); rst_n = 1'b1; req0_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("t31_no_rsp", {rsp1_valid, rsp0_valid, busy}, 0);
    end

    // Both requesters valid continuously: collect four grants
    ng = 0;
    for (int cyc = 0; cyc < 40 && ng < 4; cyc++) begin
      @(negedge clk);
      req0_valid = 1; req0_op = ALU_ADD; req0_a = 10; req0_b = cyc;
      req1_valid = 1; req1_op = ALU_SUB; req1_a = 50; req1_b = cyc;
      rsp0_ready = 1; rsp1_ready = 1;
      #1;
      if (req0_ready) begin grants[ng] = 0; ng++; $display("txn grant req0 cyc=%0d", cyc); end
      else if (req1_ready) begin grants[ng] = 1; ng++; $display("txn grant req1 cyc=%0d", cyc); end
    end
    check("t28_grant_count", ng, 4);
    for (int i = 0; i < ng; i++) begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
      check($sformatf("t28_grant%0d", i), grants[i], 0);
`else
      check($sformatf("t28_grant%0d", i), grants[i], i % 2);
`endif
    end
    @(negedge clk); req0_valid = 0; req1_valid = 0;
    repeat (3) @(negedge clk);
    #1;
    check("t28_drained", busy, 0);

    // Response stall on requester 1 with requester 0 waiting
    @(negedge clk);
    req1_valid = 1; req1_op = ALU_ADD; req1_a = 100; req1_b = 23;
    rsp1_ready = 0; rsp0_ready = 1; #1;
    check("t29_accept1", req1_ready, 1);
    @(negedge clk);
    req1_valid = 0; req0_valid = 1; req0_op = ALU_ADD; req0_a = 1; req0_b = 1; #1;
    check("t29_exec_r0", req0_ready, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("t29_rsp1_valid", {rsp1_valid, rsp0_valid}, 2'b10);
      check("t29_rsp_res", rsp_res, 123);
      check("t29_rsp_zero", rsp_zero, 0);
      check("t29_req0_ready", req0_ready, 0);
    end
    @(negedge clk); rsp1_ready = 1; #1;
    check("t29_still_valid", rsp1_valid, 1);
    $display("txn stalled req1 res=%0d", rsp_res);
    @(negedge clk); #1;
    check("t29_released", rsp1_valid, 0);
    check("t29_req0_grant", req0_ready, 1);
    @(negedge clk); req0_valid = 0; rsp1_ready = 0;
    @(negedge clk); #1;
    check("t29_req0_res", rsp_res, 2);
    check("t29_req0_valid", rsp0_valid, 1);

    // XOR producing zero
    @(negedge clk);
    req0_valid = 1; req0_op = ALU_XOR; req0_a = 3; req0_b = 3; #1;
    check("t30_accept", req0_ready, 1);
    @(negedge clk); req0_valid = 0;
    @(negedge clk); #1;
    check("t30_rsp_valid", rsp0_valid, 1);
    check("t30_rsp_zero", rsp_zero, 1);
    check("t30_rsp_res", rsp_res, 0);
    $display("txn xor req0 res=%0d zero=%0d", rsp_res, rsp_zero);

    // Requester 1 changes operands every cycle until accepted
    @(negedge clk);
    req0_valid = 1; req0_op = ALU_ADD; req0_a = 4; req0_b = 4; #1;
    check("t32_req0_accept", req0_ready, 1);
    captured = 0; exp_a = 0; exp_b = 0;
    for (int i = 1; i <= 10 && !captured; i++) begin
      @(negedge clk);
      req0_valid = 0;
      req1_valid = 1; req1_op = ALU_ADD; req1_a = 10 * i; req1_b = i;
      #1;
      if (req1_ready) begin
        captured = 1; exp_a = 10 * i; exp_b = i;
      end
    end
    check("t32_captured", captured, 1);
    check("t32_accept_cycle", exp_a, 30);
    @(negedge clk);
    req1_valid = 0; req1_a = 32'hdead; req1_b = 32'hbeef; rsp1_ready = 1; #1;
    check("t32_alu_a", alu_a, exp_a);
    check("t32_alu_b", alu_b, exp_b);
    @(negedge clk); #1;
    check("t32_rsp_valid", rsp1_valid, 1);
    check("t32_rsp_res", rsp_res, exp_a + exp_b);
    $display("txn sampled req1 res=%0d", rsp_res);
    @(negedge clk); #1;
    check("t32_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
